// File: rtl/mc_main_fsm.sv
// mc_main_fsm
// Main control state machine for the multicycle ARM core. Sequences the
// shared memory port and shared ALU through fetch / decode / address /
// access / writeback steps for data-processing, load/store (word, byte,
// halfword) and B/BL instructions. Write and branch outputs are
// unconditioned intents; condition gating happens downstream.
//
// Ports:
//   clk         core clock, rising-edge
//   reset       asynchronous active-low reset
//   Op          instruction [27:26]
//   Funct       instruction [25:20]
//   Src2        instruction [11:0] (only [7] and [4] used)
//   MemReady    memory completes the current request this cycle
//   MemReq      memory request (fetch, load, store)
//   AdrSrc      address select: 0 = PC, 1 = ALU result register
//   IRWrite     instruction register load strobe
//   NextPC      PC load strobe
//   ALUSrcA     0 = Rn, 1 = PC
//   ALUSrcB     00 Rm, 01 ext imm, 10 const 4, 11 const 0
//   ResultSrc   00 ALU result reg, 01 read data, 10 ALU result direct
//   RegW        register write intent
//   MemW        memory write intent
//   Branch      branch intent
//   ALUOp       ALU decoder enable
//   BLSrc       force write destination to R14
//   InstrDone   one-cycle retire pulse
//   Illegal     one-cycle pulse on decode of Op = 11
//   RetireCount retired instruction count (wraps)
module mc_main_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [11:0] Src2,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        NextPC,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic        RegW,
  output logic        MemW,
  output logic        Branch,
  output logic        ALUOp,
  output logic        BLSrc,
  output logic        InstrDone,
  output logic        Illegal,
  output logic [31:0] RetireCount
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_LINK   = 4'd10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic        is_mem_s;
  logic        is_cmp_s;
  logic        unused_s;

  // Memory class: LDR/STR family, or the extra-memory halfword/signed forms
  // that share Op = 00 but carry Src2[7] = Src2[4] = 1 with Funct[5] = 0.
  assign is_mem_s = (Op == 2'b01) |
                    ((Op == 2'b00) & ~Funct[5] & Src2[7] & Src2[4]);
  // Compare class (TST/TEQ/CMP/CMN) produces flags only, no writeback.
  assign is_cmp_s = (Funct[4:3] == 2'b10);
  assign unused_s = ^{Funct[2:1], Src2[11:8], Src2[6:5], Src2[3:0]};

  assign RetireCount = retire_count_q;

  // State and retire counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_FETCH;
      retire_count_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (MemReady) state_d = S_DECODE;
        else          state_d = S_FETCH;
      end
      S_DECODE: begin
        if (is_mem_s) begin
          state_d = S_MEMADR;
        end else if (Op == 2'b00) begin
          if (Funct[5]) state_d = S_EXECI;
          else          state_d = S_EXECR;
        end else if (Op == 2'b10) begin
          if (Funct[4]) state_d = S_LINK;
          else          state_d = S_BRANCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (Funct[0]) state_d = S_MEMRD;
        else          state_d = S_MEMWR;
      end
      S_MEMRD: begin
        if (MemReady) state_d = S_MEMWB;
        else          state_d = S_MEMRD;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (MemReady) state_d = S_FETCH;
        else          state_d = S_MEMWR;
      end
      S_EXECR, S_EXECI: begin
        if (is_cmp_s) state_d = S_FETCH;
        else          state_d = S_ALUWB;
      end
      S_ALUWB:  state_d = S_FETCH;
      S_LINK:   state_d = S_BRANCH;
      S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; strobes are forced low while reset is held.
  always_comb begin
    MemReq    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    BLSrc     = 1'b0;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Illegal   = (Op == 2'b11);
        InstrDone = (Op == 2'b11);
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      S_MEMWR: begin
        MemReq    = 1'b1;
        MemW      = 1'b1;
        AdrSrc    = 1'b1;
        InstrDone = MemReady;
      end
      S_EXECR: begin
        ALUOp     = 1'b1;
        InstrDone = is_cmp_s;
      end
      S_EXECI: begin
        ALUOp     = 1'b1;
        ALUSrcB   = 2'b01;
        InstrDone = is_cmp_s;
      end
      S_ALUWB: begin
        RegW      = 1'b1;
        InstrDone = 1'b1;
      end
      S_LINK: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b11;
        ResultSrc = 2'b10;
        RegW      = 1'b1;
        BLSrc     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        InstrDone = 1'b1;
      end
      default: begin
        MemReq = 1'b0;
      end
    endcase
    if (!reset) begin
      MemReq    = 1'b0;
      IRWrite   = 1'b0;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end else begin
      BLSrc = BLSrc;
    end
  end

  // Retire counter advances on every retiring cycle.
  always_comb begin
    if (InstrDone) retire_count_d = retire_count_q + 32'd1;
    else           retire_count_d = retire_count_q;
  end

endmodule

// File: tb/tb_mc_main_fsm.sv
module tb_mc_main_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [11:0] Src2;
  logic        MemReady;
  logic        MemReq, AdrSrc, IRWrite, NextPC, ALUSrcA;
  logic [1:0]  ALUSrcB, ResultSrc;
  logic        RegW, MemW, Branch, ALUOp, BLSrc, InstrDone, Illegal;
  logic [31:0] RetireCount;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_count = 32'd0;

  mc_main_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Src2(Src2),
    .MemReady(MemReady), .MemReq(MemReq), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .NextPC(NextPC), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .BLSrc(BLSrc),
    .InstrDone(InstrDone), .Illegal(Illegal), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Abstract instruction steps used by the reference model.
  typedef enum int {T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                    T_EXECR, T_EXECI, T_ALUWB, T_LINK, T_BRANCH} step_t;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [11:0] src2;
    logic [31:0] rdy;   // bit i = MemReady in cycle i of the instruction
    int          cyc;   // expected total cycles
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] dut_outs();
    return {MemReq, AdrSrc, IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc,
            RegW, MemW, Branch, ALUOp, BLSrc, InstrDone, Illegal};
  endfunction

  function automatic bit is_wait_step(step_t s);
    return (s == T_FETCH) || (s == T_MEMRD) || (s == T_MEMWR);
  endfunction

  // Expected output vector for one step; done = instruction retires now.
  function automatic logic [15:0] exp_outs(step_t s, logic r, logic [1:0] op, logic done);
    logic mreq, adr, irw, npc, srca, regw, memw, br, aluop, bl, ill;
    logic [1:0] srcb, res;
    {mreq, adr, irw, npc, srca, regw, memw, br, aluop, bl, ill} = 11'd0;
    srcb = 2'd0; res = 2'd0;
    case (s)
      T_FETCH:  begin mreq = 1'b1; srca = 1'b1; srcb = 2'd2; res = 2'd2; irw = r; npc = r; end
      T_DECODE: begin srca = 1'b1; srcb = 2'd2; res = 2'd2; ill = (op == 2'd3); end
      T_MEMADR: srcb = 2'd1;
      T_MEMRD:  begin mreq = 1'b1; adr = 1'b1; end
      T_MEMWB:  begin res = 2'd1; regw = 1'b1; end
      T_MEMWR:  begin mreq = 1'b1; adr = 1'b1; memw = 1'b1; end
      T_EXECR:  aluop = 1'b1;
      T_EXECI:  begin aluop = 1'b1; srcb = 2'd1; end
      T_ALUWB:  regw = 1'b1;
      T_LINK:   begin srca = 1'b1; srcb = 2'd3; res = 2'd2; regw = 1'b1; bl = 1'b1; end
      T_BRANCH: begin srcb = 2'd1; res = 2'd2; br = 1'b1; end
      default:  ill = 1'b0;
    endcase
    return {mreq, adr, irw, npc, srca, srcb, res, regw, memw, br, aluop, bl, done, ill};
  endfunction

  // Runs one instruction, checking every cycle against the step plan.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] f,
                           input logic [11:0] s2, input logic [31:0] rdy, output int cyc);
    step_t steps[$];
    int    idx;
    logic  r, last, waiting;
    steps.push_back(T_FETCH);
    steps.push_back(T_DECODE);
    if (op == 2'd1 || (op == 2'd0 && !f[5] && s2[7] && s2[4])) begin
      steps.push_back(T_MEMADR);
      if (f[0]) begin steps.push_back(T_MEMRD); steps.push_back(T_MEMWB); end
      else      steps.push_back(T_MEMWR);
    end else if (op == 2'd0) begin
      steps.push_back(f[5] ? T_EXECI : T_EXECR);
      if (f[4:3] != 2'b10) steps.push_back(T_ALUWB);
    end else if (op == 2'd2) begin
      if (f[4]) steps.push_back(T_LINK);
      steps.push_back(T_BRANCH);
    end
    idx = 0;
    cyc = 0;
    while (idx < steps.size() && cyc < 64) begin
      @(negedge clk);
      Op = op; Funct = f; Src2 = s2;
      r = (cyc < 32) ? rdy[cyc] : 1'b1;
      MemReady = r;
      #1;
      last    = (idx == steps.size() - 1);
      waiting = is_wait_step(steps[idx]) && !r;
      chk($sformatf("%s outs c%0d step%0d", name, cyc, steps[idx]),
          {16'd0, dut_outs()}, {16'd0, exp_outs(steps[idx], r, op, last && !waiting)});
      chk($sformatf("%s retire c%0d", name, cyc), RetireCount, model_count);
      if (!waiting) begin
        if (last) model_count = model_count + 32'd1;
        idx++;
      end
      cyc++;
    end
    if (idx < steps.size()) chk($sformatf("%s timeout", name), idx, steps.size());
  endtask

  vec_t tbl[15];

  initial begin
    int cyc;
    tbl[0]  = '{"add_reg",   2'd0, 6'b001000, 12'h000, 32'hFFFF_FFFF, 4};
    tbl[1]  = '{"add_imm",   2'd0, 6'b101000, 12'h0FF, 32'hFFFF_FFFF, 4};
    tbl[2]  = '{"cmp_reg",   2'd0, 6'b010101, 12'h000, 32'hFFFF_FFFF, 3};
    tbl[3]  = '{"cmp_imm",   2'd0, 6'b110101, 12'h0B0, 32'hFFFF_FFFF, 3};
    tbl[4]  = '{"ldr",       2'd1, 6'b011001, 12'h004, 32'hFFFF_FFFF, 5};
    tbl[5]  = '{"str",       2'd1, 6'b011000, 12'h004, 32'hFFFF_FFFF, 4};
    tbl[6]  = '{"ldr_wait",  2'd1, 6'b011001, 12'h004, 32'hFFFF_FFDC, 8};
    tbl[7]  = '{"strh",      2'd0, 6'b000000, 12'h0B0, 32'hFFFF_FFFF, 4};
    tbl[8]  = '{"ldrh",      2'd0, 6'b000001, 12'h0B0, 32'hFFFF_FFFF, 5};
    tbl[9]  = '{"strh_wait", 2'd0, 6'b000000, 12'h0B0, 32'hFFFF_FFE7, 6};
    tbl[10] = '{"b",         2'd2, 6'b100000, 12'h123, 32'hFFFF_FFFF, 3};
    tbl[11] = '{"bl",        2'd2, 6'b110000, 12'h123, 32'hFFFF_FFFF, 4};
    tbl[12] = '{"illegal",   2'd3, 6'b000000, 12'h000, 32'hFFFF_FFFF, 2};
    tbl[13] = '{"add_fwait", 2'd0, 6'b001000, 12'h000, 32'hFFFF_FFFE, 5};
    tbl[14] = '{"ldrb",      2'd1, 6'b011101, 12'h010, 32'hFFFF_FFFF, 5};

    reset = 1'b0; MemReady = 1'b1; Op = 2'd0; Funct = 6'd0; Src2 = 12'd0;
    // Reset state: strobes low, FETCH selects visible, counter clear.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", {16'd0, dut_outs()}, {16'd0, 16'b0_0_0_0_1_10_10_0_0_0_0_0_0_0});
    chk("rst_count", RetireCount, 32'd0);
    @(negedge clk);
    reset = 1'b1; MemReady = 1'b0;
    #1;
    chk("first_memreq", {31'd0, MemReq}, 32'd1);

    // Table-driven latency and per-cycle output checks.
    foreach (tbl[i]) begin
      run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].src2, tbl[i].rdy, cyc);
      chk($sformatf("%s cycles", tbl[i].name), cyc, tbl[i].cyc);
    end

    // Reset in the middle of a MEMRD wait.
    @(negedge clk); Op = 2'd1; Funct = 6'b011001; MemReady = 1'b1;   // FETCH
    @(negedge clk);                                                   // DECODE
    @(negedge clk); MemReady = 1'b0;                                  // MEMADR
    @(negedge clk); #1;                                               // MEMRD wait
    chk("mid_rd_memreq", {30'd0, MemReq, AdrSrc}, 32'd3);
    @(negedge clk);
    reset = 1'b0; MemReady = 1'b1;
    #1;
    chk("mid_rst_outs", {16'd0, dut_outs()}, {16'd0, 16'b0_0_0_0_1_10_10_0_0_0_0_0_0_0});
    chk("mid_rst_count", RetireCount, 32'd0);
    model_count = 32'd0;
    @(negedge clk); #1;
    chk("mid_rst_hold", {29'd0, MemReq, RegW, MemW}, 32'd0);
    reset = 1'b1; MemReady = 1'b0;
    #1;
    chk("mid_rst_release", {16'd0, dut_outs()}, {16'd0, 16'b1_0_0_0_1_10_10_0_0_0_0_0_0_0});
    run_instr("after_rst_add", 2'd0, 6'b001000, 12'h000, 32'hFFFF_FFFF, cyc);
    chk("after_rst_cycles", cyc, 4);

    // Counter wrap from all-ones.
    @(negedge clk);
    MemReady = 1'b0;
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    model_count = 32'hFFFF_FFFF;
    run_instr("wrap_b", 2'd2, 6'b100000, 12'h000, 32'hFFFF_FFFF, cyc);
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    chk("wrap_count", RetireCount, 32'd0);

    // Randomized instructions and memory readiness.
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  rop;
      logic [5:0]  rf;
      logic [11:0] rs;
      logic [31:0] rr;
      rop = 2'($urandom_range(0, 3));
      rf  = 6'($urandom);
      rs  = 12'($urandom);
      rr  = $urandom | $urandom | 32'hFFFF_F000;
      run_instr($sformatf("rnd%0d", n), rop, rf, rs, rr, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
